multi_cycle_controller: RTL
===========================

Name: multi_cycle_controller

Overview:
- Main control FSM for the multicycle MIPS datapath: fetch, decode, execute, memory and writeback.
- Decodes operation/func from the instruction register and drives every datapath select and write enable, plus the memory write strobe.
- Honours a memory ready handshake and keeps a retired-instruction counter for debug.

Parameters:
CNT_W, 32, width of retired-instruction counter instr_count (wraps modulo 2^CNT_W)

Ports:
clk  input  1  clock, all state changes on rising edge
rst  input  1  reset; asynchronous, active-low
operation  input  6  opcode, instruction bits [31:26]
func  input  6  function field, instruction bits [5:0]
zero  input  1  ALU zero flag, combinational, current cycle
mem_ready  input  1  memory completes the access this cycle
reg_we  output  1  register file write enable
reg_write_addr  output  2  write address select: 0 rt, 1 rd, 2 r31
reg_write_data  output  2  write data select: 0 ALU register, 1 memory data register, 2 pc
instr_reg_we  output  1  instruction register load enable
instr_or_data  output  1  memory address select: 0 pc, 1 ALU register
pc_reg_we  output  1  pc load enable, branch condition already folded in
mem_we  output  1  data memory write strobe
alu_src_a  output  2  ALU A select: 0 pc, 1 rs register, 2 rt register
alu_src_b  output  3  ALU B select: 0 rt, 1 constant 4, 2 sign-extended immediate, 3 immediate<<2, 4 shamt
pc_src  output  2  next-pc select: 0 ALU result, 1 ALU register, 2 jump target, 3 rs register
alu_controller  output  3  ALU operation code: 000 AND, 001 OR, 010 ADD, 011 SLL, 100 SRL, 110 SUB, 111 SLT
illegal_instr  output  1  one-cycle pulse in DECODE on an unsupported opcode or func
retire  output  1  one-cycle pulse on the final cycle of each legal instruction
instr_count  output  CNT_W  count of retired instructions

Behaviour:
- Reset (rst low, asynchronous): state goes to FETCH, instr_count is 0.
- While rst is low, reg_we, instr_reg_we, pc_reg_we, mem_we, illegal_instr and retire are all 0. All selects are 0.
- Outputs are a Moore decode of the state, except pc_reg_we in BRANCH (depends on zero) and the waits on mem_ready.
- Default for every output in every state is 0 unless listed below.
- Supported instructions:
  - R-type (op 0x00) with func add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A, sll 0x00, srl 0x02, jr 0x08.
  - j 0x02, jal 0x03, beq 0x04, bne 0x05, addi 0x08, slti 0x0A, lw 0x23, sw 0x2B.
- FETCH:
  - Drives instr_or_data=0, alu_src_a=0, alu_src_b=1, ADD, pc_src=0.
  - If mem_ready: instr_reg_we=1, pc_reg_we=1, then DECODE. Otherwise stay in FETCH with both enables at 0.
- DECODE: alu_src_a=0, alu_src_b=3, ADD, so the branch target is latched into the ALU register. Dispatch on op/func:
  - lw or sw: MEM_ADDR
  - R-type ALU op: R_EXEC
  - sll or srl: SHIFT_EXEC
  - jr: JR
  - addi or slti: I_EXEC
  - beq or bne: BRANCH
  - j: JUMP
  - jal: JAL
  - anything else: illegal_instr=1, then FETCH, no retire.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, ADD. Next is MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: instr_or_data=1. Hold until mem_ready, then MEM_WB.
- MEM_WB: reg_we=1, reg_write_addr=0, reg_write_data=1, retire. Next is FETCH.
- MEM_WRITE: instr_or_data=1, mem_we=1 on every cycle of the state. Leave when mem_ready: retire, then FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=0, ALU code from func (add ADD, sub SUB, and AND, or OR, slt SLT). Next is ALU_WB.
- SHIFT_EXEC: alu_src_a=2, alu_src_b=4, SLL or SRL. Next is ALU_WB.
- ALU_WB: reg_we=1, reg_write_addr=1, reg_write_data=0, retire. Next is FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=2, ADD for addi, SLT for slti. Next is I_WB.
- I_WB: reg_we=1, reg_write_addr=0, reg_write_data=0, retire. Next is FETCH.
- BRANCH:
  - alu_src_a=1, alu_src_b=0, SUB, pc_src=1.
  - pc_reg_we = zero for beq, ~zero for bne.
  - retire, then FETCH.
- JUMP: pc_src=2, pc_reg_we=1, retire, then FETCH.
- JAL:
  - pc_src=2, pc_reg_we=1.
  - reg_we=1, reg_write_addr=2, reg_write_data=2, so pc+4 (already incremented) is written to r31.
  - retire, then FETCH.
- JR: pc_src=3, pc_reg_we=1, retire, then FETCH.
- Cycle counts with mem_ready always high:
  - lw 5; sw 4; R-type and shifts 4; addi and slti 4.
  - beq, bne, j, jal, jr 3; illegal 2.
- Each memory wait cycle adds 1 to the count.
- instr_count increments on every retire pulse and wraps.
- Reset asserted mid-instruction abandons it immediately; no retire, no count.

Decomposition:
- Package mips_ctrl_pkg holds:
  - the state enum;
  - opcode and func constants;
  - ALU op codes;
  - reg_write_addr, reg_write_data, alu_src_a, alu_src_b and pc_src select constants.
- Sub-module alu_decoder: combinational func to alu_controller for R-type, instantiated once.

Test Plan:
- Release reset, mem_ready=1, op 0x23 (lw): states FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB; reg_we=1 with select 0/1 in cycle 5; instr_count goes 0 to 1.
- sw with mem_ready low for 2 cycles in MEM_WRITE: mem_we held for 3 cycles, retire only in the third; total 6 cycles.
- beq with zero=1: pc_reg_we=1, pc_src=1. beq with zero=0: pc_reg_we=0. bne gives the inverse. Each takes 3 cycles.
- jal: in cycle 3 reg_we=1, reg_write_addr=2, reg_write_data=2, pc_src=2, pc_reg_we=1.
- R-type sll (func 0x00) drives alu_src_a=2, alu_src_b=4, alu_controller 011; func 0x2A drives 111. op 0x00 with func 0x3F pulses illegal_instr, no retire, instr_count unchanged.
- Assert rst in MEM_READ: all enables drop to 0 immediately, state returns to FETCH, instr_count=0; on release, fetch resumes normally.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, opcode/func
// values, ALU operation codes, datapath select values and the control bundle.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEM_ADDR,
    S_MEM_READ,
    S_MEM_WB,
    S_MEM_WRITE,
    S_R_EXEC,
    S_SHIFT_EXEC,
    S_ALU_WB,
    S_I_EXEC,
    S_I_WB,
    S_BRANCH,
    S_JUMP,
    S_JAL,
    S_JR
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SLL = 3'b011;
  localparam logic [2:0] ALU_SRL = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] RWA_RT  = 2'd0;
  localparam logic [1:0] RWA_RD  = 2'd1;
  localparam logic [1:0] RWA_R31 = 2'd2;

  localparam logic [1:0] RWD_ALU = 2'd0;
  localparam logic [1:0] RWD_MEM = 2'd1;
  localparam logic [1:0] RWD_PC  = 2'd2;

  localparam logic [1:0] SRCA_PC = 2'd0;
  localparam logic [1:0] SRCA_RS = 2'd1;
  localparam logic [1:0] SRCA_RT = 2'd2;

  localparam logic [2:0] SRCB_RT     = 3'd0;
  localparam logic [2:0] SRCB_FOUR   = 3'd1;
  localparam logic [2:0] SRCB_IMM    = 3'd2;
  localparam logic [2:0] SRCB_IMM_SH = 3'd3;
  localparam logic [2:0] SRCB_SHAMT  = 3'd4;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUREG = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_RS     = 2'd3;

  typedef struct packed {
    logic       reg_we;
    logic [1:0] reg_write_addr;
    logic [1:0] reg_write_data;
    logic       instr_reg_we;
    logic       instr_or_data;
    logic       pc_reg_we;
    logic       mem_we;
    logic [1:0] alu_src_a;
    logic [2:0] alu_src_b;
    logic [1:0] pc_src;
    logic [2:0] alu_controller;
    logic       illegal_instr;
    logic       retire;
  } ctrl_t;

endpackage

// File: rtl/alu_decoder.sv
// R-type func field to ALU operation, plus class flags used by the dispatcher.
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] func,
  output logic [2:0] alu_ctl,
  output logic       is_alu,
  output logic       is_shift
);

  always_comb begin
    alu_ctl  = ALU_ADD;
    is_alu   = 1'b0;
    is_shift = 1'b0;
    case (func)
      FN_ADD: begin alu_ctl = ALU_ADD; is_alu = 1'b1; end
      FN_SUB: begin alu_ctl = ALU_SUB; is_alu = 1'b1; end
      FN_AND: begin alu_ctl = ALU_AND; is_alu = 1'b1; end
      FN_OR:  begin alu_ctl = ALU_OR;  is_alu = 1'b1; end
      FN_SLT: begin alu_ctl = ALU_SLT; is_alu = 1'b1; end
      FN_SLL: begin alu_ctl = ALU_SLL; is_shift = 1'b1; end
      FN_SRL: begin alu_ctl = ALU_SRL; is_shift = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: rtl/multi_cycle_controller.sv
// Multicycle MIPS main control FSM: state register plus a mostly-Moore decode of
// every datapath select/enable, with mem_ready waits and a retired-instruction count.
module multi_cycle_controller
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       operation,
  input  logic [5:0]       func,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             reg_we,
  output logic [1:0]       reg_write_addr,
  output logic [1:0]       reg_write_data,
  output logic             instr_reg_we,
  output logic             instr_or_data,
  output logic             pc_reg_we,
  output logic             mem_we,
  output logic [1:0]       alu_src_a,
  output logic [2:0]       alu_src_b,
  output logic [1:0]       pc_src,
  output logic [2:0]       alu_controller,
  output logic             illegal_instr,
  output logic             retire,
  output logic [CNT_W-1:0] instr_count
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  ctrl_t            ctrl, ctrl_out;

  logic [2:0] fn_alu;
  logic       fn_is_alu, fn_is_shift;

  alu_decoder u_alu_dec (
    .func     (func),
    .alu_ctl  (fn_alu),
    .is_alu   (fn_is_alu),
    .is_shift (fn_is_shift)
  );

  always_comb begin
    ctrl    = '0;
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        ctrl.instr_or_data  = 1'b0;
        ctrl.alu_src_a      = SRCA_PC;
        ctrl.alu_src_b      = SRCB_FOUR;
        ctrl.alu_controller = ALU_ADD;
        ctrl.pc_src         = PCSRC_ALU;
        if (mem_ready) begin
          ctrl.instr_reg_we = 1'b1;
          ctrl.pc_reg_we    = 1'b1;
          state_d           = S_DECODE;
        end
      end
      S_DECODE: begin
        // Speculatively compute pc+4 + (imm<<2) so BRANCH can use the ALU register.
        ctrl.alu_src_a      = SRCA_PC;
        ctrl.alu_src_b      = SRCB_IMM_SH;
        ctrl.alu_controller = ALU_ADD;
        case (operation)
          OP_LW, OP_SW:     state_d = S_MEM_ADDR;
          OP_ADDI, OP_SLTI: state_d = S_I_EXEC;
          OP_BEQ, OP_BNE:   state_d = S_BRANCH;
          OP_J:             state_d = S_JUMP;
          OP_JAL:           state_d = S_JAL;
          OP_RTYPE: begin
            if (fn_is_alu)          state_d = S_R_EXEC;
            else if (fn_is_shift)   state_d = S_SHIFT_EXEC;
            else if (func == FN_JR) state_d = S_JR;
            else begin
              ctrl.illegal_instr = 1'b1;
              state_d            = S_FETCH;
            end
          end
          default: begin
            ctrl.illegal_instr = 1'b1;
            state_d            = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a      = SRCA_RS;
        ctrl.alu_src_b      = SRCB_IMM;
        ctrl.alu_controller = ALU_ADD;
        state_d             = (operation == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        ctrl.instr_or_data = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        ctrl.reg_we         = 1'b1;
        ctrl.reg_write_addr = RWA_RT;
        ctrl.reg_write_data = RWD_MEM;
        ctrl.retire         = 1'b1;
        state_d             = S_FETCH;
      end
      S_MEM_WRITE: begin
        // Strobe stays up for the whole access; the store retires on the ready cycle.
        ctrl.instr_or_data = 1'b1;
        ctrl.mem_we        = 1'b1;
        if (mem_ready) begin
          ctrl.retire = 1'b1;
          state_d     = S_FETCH;
        end
      end
      S_R_EXEC: begin
        ctrl.alu_src_a      = SRCA_RS;
        ctrl.alu_src_b      = SRCB_RT;
        ctrl.alu_controller = fn_alu;
        state_d             = S_ALU_WB;
      end
      S_SHIFT_EXEC: begin
        ctrl.alu_src_a      = SRCA_RT;
        ctrl.alu_src_b      = SRCB_SHAMT;
        ctrl.alu_controller = fn_alu;
        state_d             = S_ALU_WB;
      end
      S_ALU_WB: begin
        ctrl.reg_we         = 1'b1;
        ctrl.reg_write_addr = RWA_RD;
        ctrl.reg_write_data = RWD_ALU;
        ctrl.retire         = 1'b1;
        state_d             = S_FETCH;
      end
      S_I_EXEC: begin
        ctrl.alu_src_a      = SRCA_RS;
        ctrl.alu_src_b      = SRCB_IMM;
        ctrl.alu_controller = (operation == OP_SLTI) ? ALU_SLT : ALU_ADD;
        state_d             = S_I_WB;
      end
      S_I_WB: begin
        ctrl.reg_we         = 1'b1;
        ctrl.reg_write_addr = RWA_RT;
        ctrl.reg_write_data = RWD_ALU;
        ctrl.retire         = 1'b1;
        state_d             = S_FETCH;
      end
      S_BRANCH: begin
        ctrl.alu_src_a      = SRCA_RS;
        ctrl.alu_src_b      = SRCB_RT;
        ctrl.alu_controller = ALU_SUB;
        ctrl.pc_src         = PCSRC_ALUREG;
        ctrl.pc_reg_we      = (operation == OP_BNE) ? ~zero : zero;
        ctrl.retire         = 1'b1;
        state_d             = S_FETCH;
      end
      S_JUMP: begin
        ctrl.pc_src    = PCSRC_JUMP;
        ctrl.pc_reg_we = 1'b1;
        ctrl.retire    = 1'b1;
        state_d        = S_FETCH;
      end
      S_JAL: begin
        // PC already holds pc+4 from FETCH; that is the link value for r31.
        ctrl.pc_src         = PCSRC_JUMP;
        ctrl.pc_reg_we      = 1'b1;
        ctrl.reg_we         = 1'b1;
        ctrl.reg_write_addr = RWA_R31;
        ctrl.reg_write_data = RWD_PC;
        ctrl.retire         = 1'b1;
        state_d             = S_FETCH;
      end
      S_JR: begin
        ctrl.pc_src    = PCSRC_RS;
        ctrl.pc_reg_we = 1'b1;
        ctrl.retire    = 1'b1;
        state_d        = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Reset blanks every output immediately, not just at the next edge.
  assign ctrl_out = rst ? ctrl : '0;

  always_comb begin
    count_d = count_q + {{(CNT_W-1){1'b0}}, ctrl_out.retire};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign reg_we         = ctrl_out.reg_we;
  assign reg_write_addr = ctrl_out.reg_write_addr;
  assign reg_write_data = ctrl_out.reg_write_data;
  assign instr_reg_we   = ctrl_out.instr_reg_we;
  assign instr_or_data  = ctrl_out.instr_or_data;
  assign pc_reg_we      = ctrl_out.pc_reg_we;
  assign mem_we         = ctrl_out.mem_we;
  assign alu_src_a      = ctrl_out.alu_src_a;
  assign alu_src_b      = ctrl_out.alu_src_b;
  assign pc_src         = ctrl_out.pc_src;
  assign alu_controller = ctrl_out.alu_controller;
  assign illegal_instr  = ctrl_out.illegal_instr;
  assign retire         = ctrl_out.retire;
  assign instr_count    = count_q;

endmodule
